// File: rtl/vm_pkg.sv
// vm_pkg: shared FSM states, coin values/codes and the greedy change helper
// used by the vending controller and its payout unit.
package vm_pkg;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    SALE   = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vm_state_e;

  localparam int unsigned VAL_100 = 100;
  localparam int unsigned VAL_50  = 50;
  localparam int unsigned VAL_10  = 10;
  localparam int unsigned VAL_5   = 5;

  localparam logic [1:0] CODE_100 = 2'd0;
  localparam logic [1:0] CODE_50  = 2'd1;
  localparam logic [1:0] CODE_10  = 2'd2;
  localparam logic [1:0] CODE_5   = 2'd3;

  // Largest coin not exceeding value; callers only ask with value >= 5.
  function automatic logic [1:0] largest_coin(input int unsigned value);
    if (value >= VAL_100) return CODE_100;
    if (value >= VAL_50)  return CODE_50;
    if (value >= VAL_10)  return CODE_10;
    return CODE_5;
  endfunction

  function automatic int unsigned coin_value(input logic [1:0] code);
    unique case (code)
      CODE_100: return VAL_100;
      CODE_50:  return VAL_50;
      CODE_10:  return VAL_10;
      default:  return VAL_5;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_mc_if.sv
// vending_machine_mc_if: customer/actuator signal bundle of the vending controller;
// slave modport for the controller, master modport for whoever drives it.
interface vending_machine_mc_if #(
  parameter int MONEY_W = 8,
  parameter int SEL_W   = 2
);
  logic               Enable;
  logic [SEL_W-1:0]   Select;
  logic               Cancel;
  logic               OneDollar;
  logic               FiftyCents;
  logic               TenCents;
  logic               FiveCents;
  logic               Deliver;
  logic [SEL_W-1:0]   Item;
  logic [MONEY_W-1:0] Money;
  logic               ChangeValid;
  logic [1:0]         ChangeCoin;
  logic               CoinReject;
  logic               Busy;

  modport slave (
    input  Enable, Select, Cancel, OneDollar, FiftyCents, TenCents, FiveCents,
    output Deliver, Item, Money, ChangeValid, ChangeCoin, CoinReject, Busy
  );

  modport master (
    output Enable, Select, Cancel, OneDollar, FiftyCents, TenCents, FiveCents,
    input  Deliver, Item, Money, ChangeValid, ChangeCoin, CoinReject, Busy
  );
endinterface

// File: rtl/vm_change_payout.sv
// vm_change_payout: loads an amount and pays it out greedily, one registered coin
// per cycle; done_o is high together with the last coin.
module vm_change_payout
  import vm_pkg::*;
#(
  parameter int MONEY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [MONEY_W-1:0] amount_i,
  output logic               valid_o,
  output logic [1:0]         coin_o,
  output logic               done_o
);

  logic [MONEY_W-1:0] rem_q, rem_d, src, coinAmt;
  logic               valid_q, valid_d, done_q, done_d;
  logic [1:0]         coin_q, coin_d;

  // The first coin is taken straight from the loaded amount so it appears one cycle after load.
  always_comb begin
    src     = load_i ? amount_i : rem_q;
    rem_d   = '0;
    valid_d = 1'b0;
    coin_d  = 2'd0;
    done_d  = 1'b0;
    coinAmt = '0;
    if (src != '0) begin
      coin_d  = largest_coin(32'(src));
      coinAmt = MONEY_W'(coin_value(coin_d));
      rem_d   = (src >= coinAmt) ? src - coinAmt : '0;
      valid_d = 1'b1;
      done_d  = (rem_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      valid_q <= 1'b0;
      coin_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      valid_q <= valid_d;
      coin_q  <= coin_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign coin_o  = coin_q;
  assign done_o  = done_q;

endmodule

// File: rtl/vending_machine_mc.sv
// vending_machine_mc: multi-item vending FSM with credit accumulator, price table and change payout.
// Build macro VM_TIMEOUT_EN adds an idle timer in SALE that refunds like Cancel.
module vending_machine_mc
  import vm_pkg::*;
#(
  parameter int MONEY_W   = 8,
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = $clog2(NUM_ITEMS),
  parameter logic [NUM_ITEMS*MONEY_W-1:0] PRICES = {8'd125, 8'd100, 8'd75, 8'd45}
`ifdef VM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1000
`endif
) (
  input logic                 CLK,
  input logic                 RST,
  vending_machine_mc_if.slave bus
);

  vm_state_e          state_q, state_d;
  logic [SEL_W-1:0]   item_q, item_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic               deliver_q, deliver_d, reject_q, reject_d, busy_q;
  logic [MONEY_W-1:0] price, coinVal, payAmount;
  logic [MONEY_W:0]   sum;
  logic               coinAny, coinAccept, abort, timeout, payLoad, payDone;

  assign coinAny = bus.OneDollar | bus.FiftyCents | bus.TenCents | bus.FiveCents;

  always_comb begin
    coinVal = MONEY_W'(VAL_5);
    if (bus.OneDollar)       coinVal = MONEY_W'(VAL_100);
    else if (bus.FiftyCents) coinVal = MONEY_W'(VAL_50);
    else if (bus.TenCents)   coinVal = MONEY_W'(VAL_10);
  end

  // One extra bit on the sum exposes credit overflow without wrapping.
  assign sum   = {1'b0, credit_q} + {1'b0, coinVal};
  assign price = PRICES[int'(item_q)*MONEY_W +: MONEY_W];
  assign abort = bus.Cancel | timeout;

`ifdef VM_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;

  assign timeout = (state_q == SALE) && (timer_q == TIMER_W'(TIMEOUT_CYC));

  always_comb begin
    timer_d = '0;
    if (state_q == SALE && !coinAccept && !timeout) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) timer_q <= '0;
    else      timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    credit_d   = credit_q;
    deliver_d  = 1'b0;
    reject_d   = 1'b0;
    coinAccept = 1'b0;
    payLoad    = 1'b0;
    payAmount  = credit_q;
    unique case (state_q)
      READY: begin
        credit_d = '0;
        reject_d = coinAny;
        if (bus.Enable) begin
          item_d  = (int'(bus.Select) >= NUM_ITEMS) ? SEL_W'(NUM_ITEMS - 1) : bus.Select;
          state_d = SALE;
        end
      end
      SALE: begin
        if (abort) begin
          credit_d = '0;
          payLoad  = (credit_q != '0);
          state_d  = (credit_q != '0) ? CHANGE : READY;
        end else if (credit_q >= price) begin
          state_d   = VEND;
          deliver_d = 1'b1;
          reject_d  = coinAny;
        end else if (coinAny) begin
          if (sum[MONEY_W]) begin
            reject_d = 1'b1;
          end else begin
            credit_d   = sum[MONEY_W-1:0];
            coinAccept = 1'b1;
          end
        end
      end
      VEND: begin
        reject_d  = coinAny;
        credit_d  = '0;
        payAmount = credit_q - price;
        payLoad   = (payAmount != '0);
        state_d   = (payAmount != '0) ? CHANGE : READY;
      end
      CHANGE: begin
        reject_d = coinAny;
        if (payDone) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= READY;
      item_q    <= '0;
      credit_q  <= '0;
      deliver_q <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      item_q    <= item_d;
      credit_q  <= credit_d;
      deliver_q <= deliver_d;
      reject_q  <= reject_d;
      busy_q    <= (state_d != READY);
    end
  end

  vm_change_payout #(.MONEY_W(MONEY_W)) uPayout (
    .clk      (CLK),
    .rst_n    (RST),
    .load_i   (payLoad),
    .amount_i (payAmount),
    .valid_o  (bus.ChangeValid),
    .coin_o   (bus.ChangeCoin),
    .done_o   (payDone)
  );

  assign bus.Deliver    = deliver_q;
  assign bus.Item       = item_q;
  assign bus.Money      = credit_q;
  assign bus.CoinReject = reject_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_vending_machine_mc.sv
// tb_vending_machine_mc: directed and randomized sales against a transaction-level
// credit/change model; build with VM_TIMEOUT_EN to also exercise the idle refund.
module tb_vending_machine_mc;

  localparam int MONEY_W   = 8;
  localparam int NUM_ITEMS = 4;
  localparam int SEL_W     = 2;
  localparam logic [NUM_ITEMS*MONEY_W-1:0] PRICES = {8'd45, 8'd255, 8'd100, 8'd125};
  localparam logic [3:0] C100 = 4'b1000;
  localparam logic [3:0] C50  = 4'b0100;
  localparam logic [3:0] C10  = 4'b0010;
  localparam logic [3:0] C5   = 4'b0001;

  int priceTable [NUM_ITEMS] = '{125, 100, 255, 45};

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  vending_machine_mc_if #(.MONEY_W(MONEY_W), .SEL_W(SEL_W)) bus ();

  vending_machine_mc #(
    .MONEY_W   (MONEY_W),
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .PRICES    (PRICES)
`ifdef VM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (20)
`endif
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    bus.OneDollar  = mask[3];
    bus.FiftyCents = mask[2];
    bus.TenCents   = mask[1];
    bus.FiveCents  = mask[0];
  endtask

  // Value credited for a coin mask: the most valuable pulse present wins.
  function automatic int coinValue(input logic [3:0] mask);
    if (mask[3]) return 100;
    if (mask[2]) return 50;
    if (mask[1]) return 10;
    if (mask[0]) return 5;
    return 0;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, bus.Busy, 0);
    checkOutput({tag, "_change_valid"}, bus.ChangeValid, 0);
    checkOutput({tag, "_money"}, bus.Money, 0);
    checkOutput({tag, "_deliver"}, bus.Deliver, 0);
  endtask

  // Expected payout is the greedy coin list for the amount, one coin per cycle.
  task automatic checkPayout(input int amount);
    int rem;
    int codes[$];
    rem = amount;
    while (rem > 0) begin
      if (rem >= 100)     begin codes.push_back(0); rem -= 100; end
      else if (rem >= 50) begin codes.push_back(1); rem -= 50;  end
      else if (rem >= 10) begin codes.push_back(2); rem -= 10;  end
      else                begin codes.push_back(3); rem -= 5;   end
    end
    foreach (codes[i]) begin
      stepCycle();
      bus.Cancel = 1'b0;
      checkOutput("change_valid", bus.ChangeValid, 1);
      checkOutput("change_coin", bus.ChangeCoin, codes[i]);
      checkOutput("payout_no_deliver", bus.Deliver, 0);
    end
    stepCycle();
    bus.Cancel = 1'b0;
    checkIdle("after_payout");
  endtask

  // One sale: coins until the price is met (then vend), otherwise cancel and refund.
  task automatic runSale(input int sel, input logic [3:0] coins[$], input bit lateCoin);
    int price;
    int credit;
    int v;
    price  = priceTable[sel];
    credit = 0;
    bus.Enable = 1'b1;
    bus.Select = SEL_W'(sel);
    stepCycle();
    bus.Enable = 1'b0;
    checkOutput("busy_after_enable", bus.Busy, 1);
    checkOutput("money_after_enable", bus.Money, 0);
    for (int i = 0; i < coins.size() && credit < price; i++) begin
      v = coinValue(coins[i]);
      applyStimulus(coins[i]);
      stepCycle();
      applyStimulus(4'b0);
      if (credit + v > 255) begin
        checkOutput("coin_reject_overflow", bus.CoinReject, 1);
      end else begin
        credit += v;
        checkOutput("coin_accept", bus.CoinReject, 0);
      end
      checkOutput("money", bus.Money, credit);
    end
    if (credit >= price) begin
      if (lateCoin) applyStimulus(C10);
      stepCycle();
      applyStimulus(4'b0);
      checkOutput("deliver", bus.Deliver, 1);
      checkOutput("item", bus.Item, sel);
      checkOutput("late_coin_reject", bus.CoinReject, lateCoin);
      checkPayout(credit - price);
    end else begin
      bus.Cancel = 1'b1;
      checkPayout(credit);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] coinSeq[$];
    logic [3:0] m;
    int sel;
    int n;
    bus.Enable = 1'b0;
    bus.Select = '0;
    bus.Cancel = 1'b0;
    applyStimulus(4'b0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", bus.Busy, 0);
    checkOutput("reset_money", bus.Money, 0);
    checkOutput("reset_deliver", bus.Deliver, 0);
    checkOutput("reset_change_valid", bus.ChangeValid, 0);
    checkOutput("reset_coin_reject", bus.CoinReject, 0);
    RST = 1'b1;
    stepCycle();

    // Item 0 at 125: 150 paid, change 25 as 10,10,5.
    coinSeq = {C100, C50};
    runSale(0, coinSeq, 1'b0);
    // Item 3 at 45: exact payment, no change.
    coinSeq = {C10, C10, C10, C10, C5};
    runSale(3, coinSeq, 1'b0);
    // Item 1 at 100: cancel after 60, refund 50,10.
    coinSeq = {C50, C10};
    runSale(1, coinSeq, 1'b0);
    // Item 2 at 255: 250 then a 10 overflows and is rejected; cancel refunds 250.
    coinSeq = {C100, C100, C50, C10};
    runSale(2, coinSeq, 1'b0);
    // Simultaneous dollar and nickel from zero credits only the dollar.
    coinSeq = {4'b1001};
    runSale(1, coinSeq, 1'b0);
    // Coin arriving in the cycle the price is met is rejected.
    coinSeq = {C50};
    runSale(3, coinSeq, 1'b1);
    // Cancel with no credit returns straight to idle.
    coinSeq = {};
    runSale(0, coinSeq, 1'b0);

    // Reset while paying out 75 change: everything clears at once and no more coins follow.
    bus.Enable = 1'b1;
    bus.Select = 2'd0;
    stepCycle();
    bus.Enable = 1'b0;
    applyStimulus(C100);
    stepCycle();
    applyStimulus(C100);
    stepCycle();
    applyStimulus(4'b0);
    stepCycle();
    stepCycle();
    checkOutput("pre_reset_change_valid", bus.ChangeValid, 1);
    checkOutput("pre_reset_change_coin", bus.ChangeCoin, 1);
    RST = 1'b0;
    #1;
    checkOutput("mid_reset_change_valid", bus.ChangeValid, 0);
    checkOutput("mid_reset_change_coin", bus.ChangeCoin, 0);
    checkOutput("mid_reset_busy", bus.Busy, 0);
    checkOutput("mid_reset_money", bus.Money, 0);
    checkOutput("mid_reset_deliver", bus.Deliver, 0);
    checkOutput("mid_reset_item", bus.Item, 0);
    stepCycle();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("post_reset_no_coin", bus.ChangeValid, 0);
      checkOutput("post_reset_busy", bus.Busy, 0);
    end

`ifdef VM_TIMEOUT_EN
    begin
      int waited;
      bus.Enable = 1'b1;
      bus.Select = 2'd1;
      stepCycle();
      bus.Enable = 1'b0;
      applyStimulus(C50);
      stepCycle();
      applyStimulus(4'b0);
      waited = 0;
      while (bus.ChangeValid !== 1'b1 && waited < 60) begin
        stepCycle();
        waited++;
      end
      checkOutput("timeout_latency", waited, 21);
      checkOutput("timeout_refund_coin", bus.ChangeCoin, 1);
      stepCycle();
      checkIdle("after_timeout");
    end
`endif

    // Randomized sales: mostly single coins, some simultaneous pulses, random late coin.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, NUM_ITEMS - 1);
      n   = $urandom_range(0, 10);
      coinSeq = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) m = 4'($urandom_range(1, 15));
        else                           m = 4'(1 << $urandom_range(0, 3));
        coinSeq.push_back(m);
      end
      runSale(sel, coinSeq, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vending_machine_mc.md
# vending_machine_mc

Multi-item, change-returning vending controller, next generation of the team's single-price vending machine. It accepts 100/50/10/5-cent coin pulses against one of `NUM_ITEMS` selectable prices. It delivers the item and pays out the overpayment one coin per cycle. It sits between the coin-acceptor front end and the dispenser/payout actuators, all on a single clock domain.

## Interface
Parameters:
- `MONEY_W`, 8, credit and price width in cents (unsigned).
- `NUM_ITEMS`, 4, number of selectable products (≥2).
- `SEL_W`, `$clog2(NUM_ITEMS)`, select width (derived).
- `PRICES`, {8'd125, 8'd100, 8'd75, 8'd45}, packed `NUM_ITEMS*MONEY_W` price table. Item 0 is the LSB slice. Every price is a nonzero multiple of 5.
- `TIMEOUT_CYC`, 1000, idle cycles before auto-refund (only with `VM_TIMEOUT_EN`).

Ports:
- `CLK`, in, 1, single clock; all logic on its rising edge.
- `RST`, in, 1, asynchronous, active-low reset.
- `Enable`, in, 1, start a transaction (sampled in READY).
- `Select`, in, `SEL_W`, item index, latched when `Enable` is accepted.
- `Cancel`, in, 1, abort the sale and refund the credit.
- `OneDollar`, `FiftyCents`, `TenCents`, `FiveCents`, in, 1 each, single-cycle coin pulses.
- `Deliver`, out, 1, one-cycle vend pulse.
- `Item`, out, `SEL_W`, latched selection; valid while `Deliver`=1.
- `Money`, out, `MONEY_W`, current credit.
- `ChangeValid`, out, 1, one payout coin this cycle.
- `ChangeCoin`, out, 2, payout coin code: 0=100, 1=50, 2=10, 3=5.
- `CoinReject`, out, 1, one-cycle pulse when an inserted coin is refused.
- `Busy`, out, 1, high in every state except READY.

## Operation
- States: READY, SALE, VEND, CHANGE. Reset sets state to READY and all outputs to 0.
- **READY**
  - Credit is held at 0.
  - If `Enable`=1: latch `Select` (an index ≥ `NUM_ITEMS` is clamped to `NUM_ITEMS-1`), go to SALE.
- **SALE**
  - Coin priority: OneDollar > FiftyCents > TenCents > FiveCents. At most one coin is credited per cycle; lower-priority simultaneous pulses are dropped without a reject.
  - If credit + coin > 2^MONEY_W−1: credit is unchanged and `CoinReject` pulses.
  - If `Cancel`=1: the coin that cycle is ignored; go to CHANGE with refund = credit and no delivery. If credit is 0, go straight to READY.
  - If registered credit ≥ price[item]: go to VEND. The coin arriving that cycle is rejected (`CoinReject`=1). Cancel wins over VEND.
- **VEND**
  - One cycle. `Deliver`=1 and `Item` is valid; change register = credit − price; `Money` becomes 0.
  - Go to CHANGE if change > 0, otherwise READY.
- **CHANGE**
  - Each cycle emits the largest coin ≤ remaining change, asserts `ChangeValid`, and subtracts the coin value.
  - When the remainder reaches 0 the state returns to READY after the last coin.
  - Coins, `Cancel` and `Enable` are ignored (any coin pulse gives `CoinReject`).
- All arithmetic is unsigned `MONEY_W`. Change never underflows because entry requires credit ≥ price.
- Reset mid-operation aborts immediately. Credit and any pending change are lost; no payout.

## Timing
- Coin pulse at cycle N appears in `Money` at N+1.
- Credit ≥ price compare uses the registered credit. `Deliver` is high at N+2 after the completing coin at N.
- First change coin is in the cycle after `Deliver`. Payout takes one cycle per coin, back to back. `Busy` drops in the cycle after the last coin.
- `Cancel` at cycle N: first refund coin at N+1.
- All outputs are registered.

## Configuration
- `VM_TIMEOUT_EN` defined:
  - A counter of `$clog2(TIMEOUT_CYC+1)` bits runs in SALE. It resets on any accepted coin and on entry to SALE.
  - On reaching `TIMEOUT_CYC` it behaves exactly like `Cancel`.
- `VM_TIMEOUT_EN` undefined: no counter; SALE waits indefinitely.

## Structure
- Package `vm_pkg`:
  - state enum (READY, SALE, VEND, CHANGE);
  - coin value constants (100/50/10/5);
  - `ChangeCoin` code constants;
  - a function returning the largest coin ≤ a value.
- Sub-module `vm_change_payout`:
  - loads an amount;
  - emits `ChangeValid`/`ChangeCoin` per cycle;
  - raises `done` on its last coin.
- The top-level FSM, credit accumulator and price mux stay in `vending_machine_mc`.

## Test plan
- Item 0 (125): insert 100, 50 → `Deliver` 2 cycles after the 50 coin, `Item`=0, then a single payout coin 10 then 10 then 5 (25 change: codes 2,2,3), then READY.
- Item 3 (45): insert 10, 10, 10, 10, 5 → `Deliver`, no `ChangeValid`, `Busy` low the next cycle.
- Item 1 (100): insert 50, 10, then `Cancel` → refund codes 1,2 (50, 10), no `Deliver`, `Money`=0 at the end.
- Credit 250 with an unreachable price (test parameter 255), insert 10 → `CoinReject`, `Money` stays 250. Simultaneous OneDollar+FiveCents from 0 → `Money`=100.
- Assert `RST`=0 mid-CHANGE → all outputs 0 immediately, state READY, no further coins. With `VM_TIMEOUT_EN` and `TIMEOUT_CYC`=20: insert 50, wait 20 cycles → refund code 1.
